// File: rtl/coolgirl_cfg_ctrl_pkg.sv
// Shared definitions for the multicart configuration controller.
// Holds register indices, bit positions, state encodings, the configuration
// payload struct and its reset defaults. The mapper logic uses the same defaults.
package coolgirl_cfg_ctrl_pkg;

  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CPU_BASE_W = 13;
  localparam int unsigned PRG_MASK_W = 7;
  localparam int unsigned CHR_MASK_W = 5;
  localparam int unsigned SRAM_PG_W  = 2;
  localparam int unsigned MAPPER_W   = 5;
  localparam int unsigned MIRROR_W   = 2;

  // Register indices (A2..A0 within the $5xxx window)
  localparam logic [2:0] REG_BASE_HI  = 3'd0;
  localparam logic [2:0] REG_BASE_LO  = 3'd1;
  localparam logic [2:0] REG_PRG_MASK = 3'd2;
  localparam logic [2:0] REG_CHR_MASK = 3'd3;
  localparam logic [2:0] REG_FLAGS    = 3'd4;
  localparam logic [2:0] REG_MAPPER   = 3'd5;
  localparam logic [2:0] REG_MIRROR   = 3'd6;
  localparam logic [2:0] REG_CTRL     = 3'd7;

  // R4 bit positions
  localparam int unsigned R4_SRAM_PG_LSB = 0;
  localparam int unsigned R4_SRAM_EN     = 2;
  localparam int unsigned R4_ROM6000     = 3;
  localparam int unsigned R4_FOUR_SCREEN = 4;
  localparam int unsigned R4_PRG_WE      = 5;
  localparam int unsigned R4_CHR_WE      = 6;

  // R7 bit positions
  localparam int unsigned R7_COMMIT = 0;
  localparam int unsigned R7_LOCK   = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [CPU_BASE_W-1:0] cpu_base;
    logic [PRG_MASK_W-1:0] prg_mask;
    logic [CHR_MASK_W-1:0] chr_mask;
    logic [SRAM_PG_W-1:0]  sram_page;
    logic                  sram_en;
    logic                  rom6000;
    logic                  four_screen;
    logic                  prg_we;
    logic                  chr_we;
    logic [MAPPER_W-1:0]   mapper;
    logic [MIRROR_W-1:0]   mirroring;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    cpu_base:    13'h0000,
    prg_mask:    7'h7E,
    chr_mask:    5'h1F,
    sram_page:   2'd0,
    sram_en:     1'b0,
    rom6000:     1'b0,
    four_screen: 1'b0,
    prg_we:      1'b1,
    chr_we:      1'b1,
    mapper:      5'd0,
    mirroring:   2'd0
  };

endpackage

// File: rtl/coolgirl_cfg_ctrl_if.sv
// CPU bus pins seen by the configuration controller.
// master: CPU side driving the bus; slave: controller sampling it.
//   romsel       /ROMSEL, must be 1 for a register access
//   cpu_rw_in    1 = read, 0 = write
//   cpu_addr_in  A14..A0
//   cpu_data_in  data bus, sampled on posedge m2
interface coolgirl_cfg_ctrl_if;
  import coolgirl_cfg_ctrl_pkg::*;

  logic              romsel;
  logic              cpu_rw_in;
  logic [ADDR_W-1:0] cpu_addr_in;
  logic [DATA_W-1:0] cpu_data_in;

  modport master (output romsel, output cpu_rw_in, output cpu_addr_in, output cpu_data_in);
  modport slave  (input  romsel, input  cpu_rw_in, input  cpu_addr_in, input  cpu_data_in);
endinterface

// File: rtl/coolgirl_cfg_ctrl.sv
// Multicart configuration controller.
// CPU writes to the $5xxx window fill shadow registers; an R7 commit copies the
// shadow bank into the active bank atomically, holds the mapper in reset for
// HOLD_CYCLES edges and optionally locks the block until the next reset.
// Ports:
//   m2, rst_n          CPU clock, synchronous active-low reset
//   bus                CPU bus (slave modport)
//   cpu_base..mirroring  active configuration (registered)
//   mapper_rst_n       low while mapper state must be cleared (registered)
//   cfg_locked         high once the lock has taken effect (registered)
module coolgirl_cfg_ctrl
  import coolgirl_cfg_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [2:0]  REG_A14_12  = 3'b101,
  parameter int unsigned LOCK_ENABLE = 1
) (
  input  logic                  m2,
  input  logic                  rst_n,
  coolgirl_cfg_ctrl_if.slave    bus,
  output logic [CPU_BASE_W-1:0] cpu_base,
  output logic [PRG_MASK_W-1:0] prg_mask,
  output logic [CHR_MASK_W-1:0] chr_mask,
  output logic [SRAM_PG_W-1:0]  sram_page,
  output logic                  sram_enabled,
  output logic                  map_rom_on_6000,
  output logic                  four_screen,
  output logic                  prg_write_enabled,
  output logic                  chr_write_enabled,
  output logic [MAPPER_W-1:0]   mapper,
  output logic [MIRROR_W-1:0]   mirroring,
  output logic                  mapper_rst_n,
  output logic                  cfg_locked
);

  state_e           state_q, state_d;
  cfg_t             shadow_q, shadow_d;
  cfg_t             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_pending_q, lock_pending_d;
  logic             mapper_rst_n_q, mapper_rst_n_d;
  logic             cfg_locked_q, cfg_locked_d;

  logic              wr;
  logic [2:0]        idx;
  logic [DATA_W-1:0] din;
  logic              commit;

  // A11..A3 are mirrored and intentionally ignored
  logic unused_addr;
  assign unused_addr = ^bus.cpu_addr_in[11:3];

  // Register window decode
  always_comb begin
    wr     = bus.romsel & ~bus.cpu_rw_in & (bus.cpu_addr_in[14:12] == REG_A14_12);
    idx    = bus.cpu_addr_in[2:0];
    din    = bus.cpu_data_in;
    commit = wr && (idx == REG_CTRL) && din[R7_COMMIT];
  end

  // Next-state: shadow writes, commit/hold sequencing, lock
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    cnt_d          = cnt_q;
    lock_pending_d = lock_pending_q;
    mapper_rst_n_d = mapper_rst_n_q;
    cfg_locked_d   = cfg_locked_q;

    // Shadow bank accepts writes in IDLE and HOLD; R7 is a command, not storage
    if (wr && (state_q != ST_LOCKED)) begin
      unique case (idx)
        REG_BASE_HI:  shadow_d.cpu_base[12:5] = din;
        REG_BASE_LO:  shadow_d.cpu_base[4:0]  = din[4:0];
        REG_PRG_MASK: shadow_d.prg_mask       = din[6:0];
        REG_CHR_MASK: shadow_d.chr_mask       = din[4:0];
        REG_FLAGS: begin
          shadow_d.sram_page   = din[R4_SRAM_PG_LSB +: SRAM_PG_W];
          shadow_d.sram_en     = din[R4_SRAM_EN];
          shadow_d.rom6000     = din[R4_ROM6000];
          shadow_d.four_screen = din[R4_FOUR_SCREEN];
          shadow_d.prg_we      = din[R4_PRG_WE];
          shadow_d.chr_we      = din[R4_CHR_WE];
        end
        REG_MAPPER:   shadow_d.mapper         = din[4:0];
        REG_MIRROR:   shadow_d.mirroring      = din[1:0];
        default:      shadow_d                = shadow_q;
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        mapper_rst_n_d = 1'b1;
        if (commit) begin
          active_d       = shadow_q;
          mapper_rst_n_d = 1'b0;
          cnt_d          = CNT_W'(HOLD_CYCLES - 1);
          lock_pending_d = din[R7_LOCK];
          state_d        = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          mapper_rst_n_d = 1'b1;
          if (lock_pending_q && (LOCK_ENABLE != 0)) begin
            state_d      = ST_LOCKED;
            cfg_locked_d = 1'b1;
          end else begin
            state_d      = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        mapper_rst_n_d = 1'b1;
        cfg_locked_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; mapper held in reset while rst_n is low
  always_ff @(posedge m2) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      shadow_q       <= CFG_DEFAULT;
      active_q       <= CFG_DEFAULT;
      cnt_q          <= '0;
      lock_pending_q <= 1'b0;
      mapper_rst_n_q <= 1'b0;
      cfg_locked_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      cnt_q          <= cnt_d;
      lock_pending_q <= lock_pending_d;
      mapper_rst_n_q <= mapper_rst_n_d;
      cfg_locked_q   <= cfg_locked_d;
    end
  end

  assign cpu_base          = active_q.cpu_base;
  assign prg_mask          = active_q.prg_mask;
  assign chr_mask          = active_q.chr_mask;
  assign sram_page         = active_q.sram_page;
  assign sram_enabled      = active_q.sram_en;
  assign map_rom_on_6000   = active_q.rom6000;
  assign four_screen       = active_q.four_screen;
  assign prg_write_enabled = active_q.prg_we;
  assign chr_write_enabled = active_q.chr_we;
  assign mapper            = active_q.mapper;
  assign mirroring         = active_q.mirroring;
  assign mapper_rst_n      = mapper_rst_n_q;
  assign cfg_locked        = cfg_locked_q;

endmodule

// File: tb/tb_coolgirl_cfg_ctrl.sv
// Directed bench for coolgirl_cfg_ctrl. Two instances share one CPU bus:
// u_dut with LOCK_ENABLE=1 and u_dut0 with LOCK_ENABLE=0.
module tb_coolgirl_cfg_ctrl;
  import coolgirl_cfg_ctrl_pkg::*;

  logic m2 = 1'b0;
  logic rst_n;
  always #5 m2 = ~m2;

  coolgirl_cfg_ctrl_if bus ();

  logic [12:0] cpu_base,  cpu_base0;
  logic [6:0]  prg_mask,  prg_mask0;
  logic [4:0]  chr_mask,  chr_mask0;
  logic [1:0]  sram_page, sram_page0;
  logic        sram_en, sram_en0, rom6000, rom60000, four_scr, four_scr0;
  logic        prg_we, prg_we0, chr_we, chr_we0;
  logic [4:0]  mapper, mapper0;
  logic [1:0]  mirroring, mirroring0;
  logic        mrst_n, mrst_n0, locked, locked0;

  coolgirl_cfg_ctrl #(.HOLD_CYCLES(4), .REG_A14_12(3'b101), .LOCK_ENABLE(1)) u_dut (
    .m2(m2), .rst_n(rst_n), .bus(bus),
    .cpu_base(cpu_base), .prg_mask(prg_mask), .chr_mask(chr_mask), .sram_page(sram_page),
    .sram_enabled(sram_en), .map_rom_on_6000(rom6000), .four_screen(four_scr),
    .prg_write_enabled(prg_we), .chr_write_enabled(chr_we), .mapper(mapper),
    .mirroring(mirroring), .mapper_rst_n(mrst_n), .cfg_locked(locked)
  );

  coolgirl_cfg_ctrl #(.HOLD_CYCLES(4), .REG_A14_12(3'b101), .LOCK_ENABLE(0)) u_dut0 (
    .m2(m2), .rst_n(rst_n), .bus(bus),
    .cpu_base(cpu_base0), .prg_mask(prg_mask0), .chr_mask(chr_mask0), .sram_page(sram_page0),
    .sram_enabled(sram_en0), .map_rom_on_6000(rom60000), .four_screen(four_scr0),
    .prg_write_enabled(prg_we0), .chr_write_enabled(chr_we0), .mapper(mapper0),
    .mirroring(mirroring0), .mapper_rst_n(mrst_n0), .cfg_locked(locked0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.romsel      = 1'b0;
    bus.cpu_rw_in   = 1'b1;
    bus.cpu_addr_in = '0;
    bus.cpu_data_in = '0;
  endtask

  // One bus cycle covering exactly one posedge; outputs valid on return
  task automatic bus_cycle(input logic rs, input logic rw, input logic [15:0] addr,
                           input logic [7:0] data);
    @(negedge m2);
    bus.romsel      = rs;
    bus.cpu_rw_in   = rw;
    bus.cpu_addr_in = addr[14:0];
    bus.cpu_data_in = data;
    @(posedge m2);
    #1;
    bus_idle();
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bus_cycle(1'b1, 1'b0, addr, data);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge m2);
    #1;
  endtask

  task automatic do_reset();
    @(negedge m2);
    rst_n = 1'b0;
    tick(2);
    check("mrst_low_in_reset", 32'(mrst_n), 32'd0);
    @(negedge m2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    bus_idle();
    rst_n = 1'b0;

    // Reset defaults
    do_reset();
    check("rst_prg_mask", 32'(prg_mask), 32'h7E);
    check("rst_chr_mask", 32'(chr_mask), 32'h1F);
    check("rst_prg_we",   32'(prg_we),   32'd1);
    check("rst_chr_we",   32'(chr_we),   32'd1);
    check("rst_cpu_base", 32'(cpu_base), 32'd0);
    check("rst_mrst_n",   32'(mrst_n),   32'd1);
    check("rst_locked",   32'(locked),   32'd0);

    // Base write, shadow only until commit, then hold for 4 edges
    wr(16'h5000, 8'hA5);
    wr(16'h5001, 8'h13);
    check("base_shadow_only", 32'(cpu_base), 32'd0);
    wr(16'h5007, 8'h01);
    check("base_committed", 32'(cpu_base), 32'h14B3);
    check("hold_e0", 32'(mrst_n), 32'd0);
    tick(1); check("hold_e1", 32'(mrst_n), 32'd0);
    tick(1); check("hold_e2", 32'(mrst_n), 32'd0);
    tick(1); check("hold_e3", 32'(mrst_n), 32'd0);
    tick(1); check("hold_release", 32'(mrst_n), 32'd1);

    // Mirrored R5, flags, chr mask, mirroring; ignored romsel=0 and read cycles
    wr(16'h5FF5, 8'h04);
    wr(16'h5004, 8'h1D);
    wr(16'h5003, 8'h0A);
    wr(16'h5006, 8'h02);
    bus_cycle(1'b0, 1'b0, 16'h5002, 8'h11);
    bus_cycle(1'b1, 1'b1, 16'h5002, 8'h22);
    wr(16'h4002, 8'h33);
    check("mapper_before_commit", 32'(mapper), 32'd0);
    wr(16'h5007, 8'h01);
    check("mapper_mirror", 32'(mapper), 32'd4);
    check("sram_page", 32'(sram_page), 32'd1);
    check("sram_en", 32'(sram_en), 32'd1);
    check("rom6000", 32'(rom6000), 32'd1);
    check("four_screen", 32'(four_scr), 32'd1);
    check("prg_we_cleared", 32'(prg_we), 32'd0);
    check("chr_we_cleared", 32'(chr_we), 32'd0);
    check("chr_mask", 32'(chr_mask), 32'h0A);
    check("mirroring", 32'(mirroring), 32'd2);
    check("prg_mask_untouched", 32'(prg_mask), 32'h7E);
    check("base_kept", 32'(cpu_base), 32'h14B3);
    tick(4);
    check("hold2_release", 32'(mrst_n), 32'd1);

    // Commit ignored in HOLD while shadow keeps accepting writes
    wr(16'h5007, 8'h01);
    wr(16'h5005, 8'h07);
    wr(16'h5007, 8'h01);
    check("hold_mapper_kept", 32'(mapper), 32'd4);
    check("hold_mrst_low", 32'(mrst_n), 32'd0);
    tick(1); check("hold_e3b", 32'(mrst_n), 32'd0);
    tick(1); check("no_second_hold_a", 32'(mrst_n), 32'd1);
    tick(1); check("no_second_hold_b", 32'(mrst_n), 32'd1);
    wr(16'h5007, 8'h01);
    check("shadow_r5_seven", 32'(mapper), 32'd7);
    tick(4);

    // Reset on the 2nd HOLD edge of a locking commit
    wr(16'h5002, 8'h00);
    wr(16'h5007, 8'h81);
    check("prg_mask_zero", 32'(prg_mask), 32'h00);
    tick(1);
    do_reset();
    check("midhold_prg_mask", 32'(prg_mask), 32'h7E);
    check("midhold_mapper", 32'(mapper), 32'd0);
    check("midhold_prg_we", 32'(prg_we), 32'd1);
    check("midhold_mrst_n", 32'(mrst_n), 32'd1);
    tick(6);
    check("no_stale_lock", 32'(locked), 32'd0);
    wr(16'h5007, 8'h01);
    check("shadow_defaulted", 32'(prg_mask), 32'h7E);
    check("shadow_base_defaulted", 32'(cpu_base), 32'd0);
    tick(4);

    // Lock: takes effect after hold; LOCK_ENABLE=0 instance never locks
    wr(16'h5002, 8'h3C);
    wr(16'h5007, 8'h81);
    check("lock_prg_mask", 32'(prg_mask), 32'h3C);
    tick(3);
    check("lock_not_yet", 32'(locked), 32'd0);
    tick(1);
    check("locked", 32'(locked), 32'd1);
    check("locked_mrst_n", 32'(mrst_n), 32'd1);
    check("lock_dis_unlocked", 32'(locked0), 32'd0);
    wr(16'h5002, 8'h00);
    wr(16'h5007, 8'h01);
    check("locked_prg_mask", 32'(prg_mask), 32'h3C);
    check("locked_no_hold", 32'(mrst_n), 32'd1);
    check("lock_dis_prg_mask", 32'(prg_mask0), 32'h00);
    check("lock_dis_hold", 32'(mrst_n0), 32'd0);
    tick(8);
    check("still_locked", 32'(locked), 32'd1);
    check("lock_dis_still_unlocked", 32'(locked0), 32'd0);

    // Reset exits LOCKED
    do_reset();
    check("unlock_prg_mask", 32'(prg_mask), 32'h7E);
    check("unlock_locked", 32'(locked), 32'd0);
    wr(16'h5005, 8'h09);
    wr(16'h5007, 8'h01);
    check("post_unlock_commit", 32'(mapper), 32'd9);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
